// File: rtl/montgomery_param_if.sv
// Request/response bundle for the Montgomery multiplier (montgomery_param).
// Handshake: start is accepted only while the block is idle (busy=0, done=0); done pulses for one cycle with result/error valid.
interface montgomery_param_if #(
    parameter int WIDTH = 1024
);
    logic             start;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_m;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        output start, in_a, in_b, in_m,
        input  result, busy, done, error
    );

    modport slave (
        input  start, in_a, in_b, in_m,
        output result, busy, done, error
    );
endinterface

// File: rtl/montgomery_param.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod M.
// Define MONTGOMERY_FINAL_SUB_EN to add the SUB state for a fully reduced result.
module montgomery_param #(
    parameter int WIDTH = 1024,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    montgomery_param_if.slave   bus,
    output logic [1:0]          state_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] m_r;
    logic [WIDTH+1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] result_r;
    logic             error_r;

    logic [WIDTH+1:0] sum1;
    logic [WIDTH+1:0] sum2;
    logic             last_iter;

    // One radix-2 step; sum2 is always even, so the shift is exact.
    always_comb begin
        sum1 = acc + (a_sh[0] ? {2'b00, b_r} : '0);
        sum2 = sum1[0] ? (sum1 + {2'b00, m_r}) : sum1;
    end

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

`ifdef MONTGOMERY_FINAL_SUB_EN
    logic [WIDTH+1:0] diff;
    assign diff = acc - {2'b00, m_r};
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start) state_nx = bus.in_m[0] ? ITER : DONE;
`ifdef MONTGOMERY_FINAL_SUB_EN
            ITER: if (last_iter) state_nx = SUB;
            SUB:  state_nx = DONE;
`else
            ITER: if (last_iter) state_nx = DONE;
`endif
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh     <= '0;
            b_r      <= '0;
            m_r      <= '0;
            acc      <= '0;
            cnt      <= '0;
            result_r <= '0;
            error_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.in_m[0]) begin
                            a_sh    <= bus.in_a;
                            b_r     <= bus.in_b;
                            m_r     <= bus.in_m;
                            acc     <= '0;
                            cnt     <= '0;
                            error_r <= 1'b0;
                        end else begin
                            error_r  <= 1'b1;
                            result_r <= '0;
                        end
                    end
                end
                ITER: begin
                    acc  <= sum2 >> 1;
                    a_sh <= a_sh >> 1;
                    cnt  <= cnt + 1'b1;
`ifndef MONTGOMERY_FINAL_SUB_EN
                    // Unreduced C (< 2M) goes straight out.
                    if (last_iter) result_r <= sum2[WIDTH:1];
`endif
                end
`ifdef MONTGOMERY_FINAL_SUB_EN
                SUB: result_r <= diff[WIDTH+1] ? acc[WIDTH-1:0] : diff[WIDTH-1:0];
`endif
                default: ;
            endcase
        end
    end

    assign bus.result = result_r;
    assign bus.error  = error_r;
    assign bus.done   = (state == DONE);
    assign bus.busy   = (state == ITER) || (state == SUB);
    assign state_dbg  = state;
endmodule

// File: tb/tb_montgomery_param.sv
// Directed bench for montgomery_param (WIDTH=8) with an expected-value queue and a done-driven monitor.
// Builds with or without MONTGOMERY_FINAL_SUB_EN.
module tb_montgomery_param;
    localparam int W = 8;
`ifdef MONTGOMERY_FINAL_SUB_EN
    localparam int LAT    = W + 2;
    localparam int BUSY_N = W + 1;
`else
    localparam int LAT    = W + 1;
    localparam int BUSY_N = W;
`endif

    typedef struct {
        logic [W-1:0] m;
        logic         err;
        int           due;
        int           busy_n;
    } meta_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   state_dbg;
    logic [W-1:0] exp_q[$];
    meta_t        meta_q[$];
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    int           bcnt = 0;
    int           done_n = 0;

    montgomery_param_if #(.WIDTH(W)) bus ();

    montgomery_param #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (bus.busy) bcnt++;
        if (bus.done) begin
            done_n++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                automatic logic [W-1:0] er = exp_q.pop_front();
                automatic meta_t        md = meta_q.pop_front();
`ifdef MONTGOMERY_FINAL_SUB_EN
                check("result", bus.result, er);
`else
                check("result_mod_m", (md.m == 0) ? bus.result : (bus.result % md.m), er);
                check("result_lt_2m", (bus.result < 2 * md.m) ? 1 : 0, 1);
`endif
                check("error", bus.error, md.err);
                check("done_cycle", cyc, md.due);
                check("busy_cycles", bcnt, md.busy_n);
            end
            bcnt = 0;
        end
    end

    // driver
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m,
                      input logic [W-1:0] r);
        meta_t md;
        @(negedge clk);
        bus.start = 1'b1;
        bus.in_a  = a;
        bus.in_b  = b;
        bus.in_m  = m;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.in_a  = $urandom_range(0, 255);
        bus.in_b  = $urandom_range(0, 255);
        bus.in_m  = $urandom_range(0, 255);
        md.m = m;
        if (m[0]) begin
            md.err = 1'b0; md.due = cyc + LAT - 1; md.busy_n = BUSY_N;
            exp_q.push_back(r);
        end else begin
            md.err = 1'b1; md.due = cyc; md.busy_n = 0;
            exp_q.push_back('0);
        end
        meta_q.push_back(md);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        meta_q.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int dn;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_m = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_result", bus.result, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_error", bus.error, 0);
        check("rst_state", state_dbg, 0);
        reset = 1'b0;
        bcnt = 0;

        op(8'd5, 8'd7, 8'd13, 8'd1);
        wait_idle();
        repeat (3) @(negedge clk);
        check("hold_result", bus.result, 1);
        check("hold_done", bus.done, 0);

        op(8'd12, 8'd12, 8'd13, 8'd3);    wait_idle();
        op(8'd0, 8'd9, 8'd13, 8'd0);      wait_idle();
        op(8'd1, 8'd1, 8'd13, 8'd3);      wait_idle();
        op(8'd100, 8'd50, 8'd127, 8'd87); wait_idle();
        op(8'd126, 8'd126, 8'd127, 8'd64); wait_idle();

        // even modulus
        op(8'd5, 8'd7, 8'd12, 8'd0);
        wait_idle();
        check("even_hold_error", bus.error, 1);
        check("even_hold_result", bus.result, 0);
        op(8'd5, 8'd7, 8'd13, 8'd1);
        wait_idle();

        // second start while busy must be ignored
        dn = done_n;
        op(8'd5, 8'd7, 8'd13, 8'd1);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.in_a = 8'd12;
        bus.in_b = 8'd12;
        bus.in_m = 8'd13;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        check("busy_start_done_once", done_n - dn, 1);

        // reset mid-operation
        op(8'd100, 8'd50, 8'd127, 8'd87);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        meta_q.delete();
        bcnt = 0;
        check("midrst_result", bus.result, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_error", bus.error, 0);
        check("midrst_state", state_dbg, 0);
        dn = done_n;
        repeat (15) @(negedge clk);
        check("midrst_no_done", done_n - dn, 0);
        op(8'd5, 8'd7, 8'd13, 8'd1);
        wait_idle();

        // reset wins over start on the same edge
        @(negedge clk);
        reset = 1'b1;
        bus.start = 1'b1;
        bus.in_m = 8'd13;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.start = 1'b0;
        check("rst_prio_state", state_dbg, 0);
        check("rst_prio_busy", bus.busy, 0);
        bcnt = 0;
        op(8'd126, 8'd126, 8'd127, 8'd64);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
